// File: rtl/base_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : base_conv_pkg
// Description : Shared definitions for the radix converter: the clog2
//               constant function and the FSM state encoding.
// Contents    : clog2()           - ceiling log2, clog2(1) = 0
//               ST_IDLE/CONV/DONE - 2-bit state codes
//               state_t           - enum view of those codes
// Revision    : 1.0 - initial release
// ============================================================================
package base_conv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CONV = ST_CONV,
    S_DONE = ST_DONE
  } state_t;

  // Ceiling log2, usable in constant expressions (parameter widths).
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/radix_divmod.sv
`default_nettype none
// ============================================================================
// Module      : radix_divmod
// Description : Combinational divide/modulo by the constant RADIX. Used once
//               per conversion step to peel off the least significant digit.
// Ports       : i_work [IN_W]    - dividend
//               o_q    [IN_W]    - quotient  i_work / RADIX
//               o_r    [DIGIT_W] - remainder i_work % RADIX (zero-extended)
// Revision    : 1.0 - initial release
// ============================================================================
module radix_divmod
  import base_conv_pkg::*;
#(
  parameter  int IN_W    = 16,
  parameter  int RADIX   = 3,
  localparam int DIGIT_W = (clog2(RADIX) < 1) ? 1 : clog2(RADIX)
) (
  input  logic [IN_W-1:0]    i_work,
  output logic [IN_W-1:0]    o_q,
  output logic [DIGIT_W-1:0] o_r
);

  // The divisor must be representable even for very narrow inputs
  // (e.g. IN_W=2 with RADIX=16), so the arithmetic runs at >= 5 bits.
  localparam int EXT_W = (IN_W > 5) ? IN_W : 5;
  localparam logic [EXT_W-1:0] C_RADIX = EXT_W'(RADIX);

  logic [EXT_W-1:0] w_ext;
  logic [EXT_W-1:0] w_q_ext;

  assign w_ext   = EXT_W'(i_work);
  assign w_q_ext = w_ext / C_RADIX;
  assign o_q     = IN_W'(w_q_ext);
  // Remainder is < RADIX, so it always fits in DIGIT_W bits.
  assign o_r     = DIGIT_W'(w_ext % C_RADIX);

endmodule
`default_nettype wire

// File: rtl/base2_to_basen.sv
`default_nettype none
// ============================================================================
// Module      : base2_to_basen
// Description : Converts an unsigned IN_W-bit binary value into RADIX digits,
//               one digit per clock, packed little-endian DIGIT_W bits each.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               en        - start request, sampled only in IDLE
//               base2_no  - value to convert, captured on the accepting edge
//               baseN_no  - digits, digit i at [i*DIGIT_W +: DIGIT_W]
//               n_digits  - number of significant digits (>= 1 after a run)
//               overflow  - value needed more than N_DIGITS digits
//               busy      - high while converting and in the done cycle
//               done      - one-cycle pulse, result valid
// Revision    : 1.0 - initial release
// ============================================================================
module base2_to_basen
  import base_conv_pkg::*;
#(
  parameter  int IN_W     = 16,
  parameter  int RADIX    = 3,
  parameter  int N_DIGITS = 16,
  localparam int DIGIT_W  = (clog2(RADIX) < 1) ? 1 : clog2(RADIX),
  localparam int CNT_W    = clog2(N_DIGITS + 1),
  localparam int OUT_W    = N_DIGITS * DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  base2_no,
  output logic [OUT_W-1:0] baseN_no,
  output logic [CNT_W-1:0] n_digits,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(N_DIGITS);

  state_t             r_state;
  logic [IN_W-1:0]    r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_acc;
  logic [OUT_W-1:0]   r_baseN_no;
  logic [CNT_W-1:0]   r_n_digits;
  logic               r_overflow;
  logic               r_busy;
  logic               r_done;

  logic [IN_W-1:0]    w_q;
  logic [DIGIT_W-1:0] w_r;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [OUT_W-1:0]   w_acc_next;
  logic               w_last;

  radix_divmod #(
    .IN_W  (IN_W),
    .RADIX (RADIX)
  ) u_divmod (
    .i_work (r_work),
    .o_q    (w_q),
    .o_r    (w_r)
  );

  assign w_cnt_inc = r_cnt + 1'b1;
  // Stop when nothing is left to convert, or when the last slot is filled
  // (any remaining quotient means the value overflowed).
  assign w_last    = (w_q == '0) || (w_cnt_inc == C_CNT_MAX);

  // Accumulator with the current digit already inserted, so the DONE
  // snapshot includes the digit produced on the exit cycle.
  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_acc_next[i*DIGIT_W +: DIGIT_W] = w_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_baseN_no <= '0;
      r_n_digits <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (en) begin
            r_work  <= base2_no;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc  <= w_acc_next;
          r_work <= w_q;
          r_cnt  <= w_cnt_inc;
          if (w_last) begin
            r_state    <= S_DONE;
            r_baseN_no <= w_acc_next;
            // In both exit cases the digit count is cnt+1 (== N_DIGITS
            // on overflow); a nonzero quotient marks the overflow case.
            r_n_digits <= w_cnt_inc;
            r_overflow <= (w_q != '0);
            r_done     <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign baseN_no = r_baseN_no;
  assign n_digits = r_n_digits;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire
